ic_irq_conditioner: RTL and testbench
=====================================

// Module: ic_irq_conditioner
// PURPOSE
//  Upstream stage of the interrupt controller. Takes raw, asynchronous peripheral
//  interrupt lines and conditions each one: synchronise, fix polarity, glitch-filter,
//  then latch as level or edge. irq_pending drives the controller's irq_in directly.
//  An edge-mode line is cleared by the controller/processor ack for that id.
// PARAMETERS
//  NUM_IRQ       8  number of interrupt lines
//  SYNC_STAGES   2  synchroniser flops per line (>=2)
//  FILTER_CYCLES 3  consecutive stable cycles required to accept a change (0 = bypass)
// PORTS
//  clk          in   1        single clock; every flop is on its rising edge
//  rst          in   1        synchronous, active-high reset
//  irq_raw      in   NUM_IRQ  asynchronous peripheral interrupt lines
//  polarity     in   NUM_IRQ  1 = line is active-low (inverted after sync)
//  edge_mode    in   NUM_IRQ  1 = rising-edge latched, 0 = level
//  ack          in   1        single-cycle acknowledge pulse
//  ack_id       in   $clog2(NUM_IRQ)  id being acknowledged, valid with ack
//  overrun_clr  in   NUM_IRQ  write-1-to-clear for overrun bits
//  irq_pending  out  NUM_IRQ  conditioned requests to the interrupt controller
//  overrun      out  NUM_IRQ  sticky: edge arrived while line already pending
// BEHAVIOUR
//  Reset: sync flops, filtered state, filter counters, edge history, irq_pending
//   and overrun all go to 0 on the first clk edge with rst=1. Reset wins over every
//   other event. A reset mid-filter discards the partial count.
//  Sync: s[i] = output of the SYNC_STAGES chain, XOR polarity[i].
//  Filter (per line): f[i] is the accepted value, cnt[i] is the counter.
//   - If s!=f and cnt==FILTER_CYCLES-1: f<=s and cnt<=0.
//   - Else if s!=f: cnt++.
//   - Else: cnt<=0, so any bounce restarts the count.
//   - FILTER_CYCLES=0: f = s with no counter.
//   - Counter width is $clog2(FILTER_CYCLES+1). The counter never wraps.
//  Level mode (edge_mode[i]=0): irq_pending[i] <= f[i]. ack is ignored.
//  Edge mode (edge_mode[i]=1): rise = f[i] & ~f_d[i], where f_d is last cycle's f.
//   - rise sets irq_pending[i].
//   - ack && ack_id==i clears it.
//   - If rise and the clear happen in the same cycle, set wins (edge not lost).
//   - An ack for a line that is not pending, or an ack_id >= NUM_IRQ, is a no-op.
//  Overrun: rise while irq_pending[i]=1 and no clear that cycle -> overrun[i]<=1.
//   - It stays set until overrun_clr[i]=1.
//   - If a set and overrun_clr happen together, set wins.
//  Mode change: if edge_mode[i] toggles, irq_pending[i] is recomputed next cycle.
//   - Level: irq_pending[i] = f[i].
//   - Edge: irq_pending[i] = 0, and f_d is kept so a held-high line gives no false edge.
//  Latency: a raw transition sampled at edge k appears on irq_pending at edge
//   k+SYNC_STAGES+FILTER_CYCLES (edge mode: same, rise is combinational into the set).
//   Default = 5 cycles.
//  All outputs are registered. There is no combinational path from input to output.
// STRUCTURE
//  Shared package ic_pkg holds:
//   - NUM_IRQ_DEF=8
//   - typedef logic [NUM_IRQ_DEF-1:0] irq_vec_t
//   - typedef logic [$clog2(NUM_IRQ_DEF)-1:0] irq_id_t
//  The design top uses the same typedefs.
//  Sub-module ic_irq_filter (one line: sync chain, polarity, glitch filter, outputs f)
//  is instantiated NUM_IRQ times in a generate loop. The latch/overrun logic stays
//  in the top.
// TESTING
//  1. Level, pol=0: irq_raw[3] 0->1 held. irq_pending[3]=1 exactly 5 cycles later.
//     Raw 1->0 drops it 5 cycles later. ack_id=3 has no effect.
//  2. Glitch: irq_raw[0] high for 2 cycles, then low. irq_pending stays 8'h00 throughout.
//     A 3-cycle pulse is accepted.
//  3. Edge: line 5 rises and is held high. irq_pending=8'h20, stays set after raw
//     falls. ack with ack_id=5 -> 8'h00 next cycle. No re-set while held high.
//  4. Edge collision: rise on line 2 in the same cycle as ack_id=2. irq_pending[2]
//     stays 1. A second rise before ack -> overrun=8'h04. overrun_clr=8'h04 clears it.
//  5. Polarity: polarity=8'h80, irq_raw[7]=1 at reset release. No pending.
//     Raw 1->0 -> irq_pending[7]=1 after 5 cycles.
//  6. Reset mid-operation: rst=1 while pending=8'hA5 and overrun=8'h01. Both are 0
//     next edge. After release, lines still high assert only after 5 cycles.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared definitions for the interrupt controller front end.
//   NUM_IRQ_DEF : default number of interrupt lines
//   irq_vec_t   : one bit per interrupt line
//   irq_id_t    : interrupt line index
package ic_pkg;
  localparam int NUM_IRQ_DEF = 8;
  typedef logic [NUM_IRQ_DEF-1:0]         irq_vec_t;
  typedef logic [$clog2(NUM_IRQ_DEF)-1:0] irq_id_t;
endpackage

// File: rtl/ic_irq_conditioner_if.sv
// Bundle of the peripheral-side and controller-side signals of the IRQ conditioner.
//   irq_raw, polarity, edge_mode, ack, ack_id, overrun_clr : driven by master
//   irq_pending, overrun                                    : driven by slave (conditioner)
interface ic_irq_if
  import ic_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF
) ();
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] irq_raw;
  logic [NUM_IRQ-1:0] polarity;
  logic [NUM_IRQ-1:0] edge_mode;
  logic               ack;
  logic [ID_W-1:0]    ack_id;
  logic [NUM_IRQ-1:0] overrun_clr;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] overrun;

  modport master (
    output irq_raw, polarity, edge_mode, ack, ack_id, overrun_clr,
    input  irq_pending, overrun
  );

  modport slave (
    input  irq_raw, polarity, edge_mode, ack, ack_id, overrun_clr,
    output irq_pending, overrun
  );
endinterface

// File: rtl/ic_irq_filter.sv
// One interrupt line: synchroniser chain, polarity fix and glitch filter.
//   clk, rst : clock and synchronous active-high reset
//   raw      : asynchronous peripheral line
//   pol      : 1 = line is active-low
//   f        : accepted (filtered) active-high level
module ic_irq_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic pol,
  output logic f
);
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;

  always_ff @(posedge clk) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
  end

  // Polarity is applied after synchronisation so the chain only ever sees the pin.
  assign s = sync_p0[SYNC_STAGES-1] ^ pol;

  // ---- filter stage ----
  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign f = s;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
      logic [CW-1:0] cnt_p1;
      logic          f_p1;

      // Any cycle where s agrees with f restarts the count, so a bounce never
      // accumulates towards acceptance.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_p1 <= '0;
          f_p1   <= 1'b0;
        end else if (s != f_p1) begin
          if (cnt_p1 == CNT_LAST) begin
            f_p1   <= s;
            cnt_p1 <= '0;
          end else begin
            cnt_p1 <= cnt_p1 + CW'(1);
          end
        end else begin
          cnt_p1 <= '0;
        end
      end

      assign f = f_p1;
    end
  endgenerate
endmodule

// File: rtl/ic_irq_conditioner.sv
// Interrupt conditioner: per line sync + polarity + glitch filter, then level or
// rising-edge latching with ack clear and sticky overrun detection.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ic_irq_if slave (raw lines, config, ack, overrun_clr in;
//              irq_pending, overrun out, both registered)
module ic_irq_conditioner
  import ic_pkg::*;
#(
  parameter int NUM_IRQ       = NUM_IRQ_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  ic_irq_if.slave     bus
);
  logic [NUM_IRQ-1:0] f;

  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
      logic f_d_p2;
      logic mode_p2;
      logic pending_p2;
      logic overrun_p2;
      logic rise;
      logic clr;
      logic enter_edge;

      ic_irq_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filter (
        .clk(clk),
        .rst(rst),
        .raw(bus.irq_raw[i]),
        .pol(bus.polarity[i]),
        .f  (f[i])
      );

      assign rise       = f[i] & ~f_d_p2;
      assign clr        = bus.ack && (int'(bus.ack_id) == i);
      // First cycle in edge mode: drop whatever level mode left behind. f_d keeps
      // tracking f in both modes, so a line already held high makes no rise here.
      assign enter_edge = bus.edge_mode[i] & ~mode_p2;

      // ---- latch stage ----
      always_ff @(posedge clk) begin
        if (rst) begin
          f_d_p2     <= 1'b0;
          mode_p2    <= 1'b0;
          pending_p2 <= 1'b0;
          overrun_p2 <= 1'b0;
        end else begin
          f_d_p2  <= f[i];
          mode_p2 <= bus.edge_mode[i];

          if (!bus.edge_mode[i])  pending_p2 <= f[i];
          else if (enter_edge)    pending_p2 <= rise;
          else if (rise)          pending_p2 <= 1'b1;  // set beats a same-cycle ack
          else if (clr)           pending_p2 <= 1'b0;

          // A rise landing on a still-pending request loses an event unless the
          // same cycle clears it; set beats overrun_clr.
          if (bus.edge_mode[i] && !enter_edge && rise && pending_p2 && !clr)
            overrun_p2 <= 1'b1;
          else if (bus.overrun_clr[i])
            overrun_p2 <= 1'b0;
        end
      end

      assign bus.irq_pending[i] = pending_p2;
      assign bus.overrun[i]     = overrun_p2;
    end
  endgenerate
endmodule

// File: tb/tb_ic_irq_conditioner.sv
module tb_ic_irq_conditioner;
  import ic_pkg::*;

  localparam int SS = 2;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ic_irq_if #(.NUM_IRQ(NUM_IRQ_DEF)) bus ();

  ic_irq_conditioner #(
    .NUM_IRQ      (NUM_IRQ_DEF),
    .SYNC_STAGES  (SS),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: raw delayed by SS samples, a line is accepted once the
  // last FC synchronised samples all disagree with the accepted value.
  irq_vec_t hist [SS];
  irq_vec_t shist[FC];
  irq_vec_t mf, mfd, mpend, movr, mmode;

  typedef struct {
    irq_vec_t raw;
    irq_vec_t em;
    logic     ack;
    irq_id_t  id;
    irq_vec_t exp_p;
    irq_vec_t exp_o;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input irq_vec_t act, input irq_vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    irq_vec_t s, nf, rise, clrv, entering, npend;
    logic flip;
    if (rst) begin
      for (int j = 0; j < SS; j++) hist[j] = '0;
      for (int j = 0; j < FC; j++) shist[j] = '0;
      mf = '0; mfd = '0; mpend = '0; movr = '0; mmode = '0;
    end else begin
      s = hist[SS-1] ^ bus.polarity;
      for (int j = FC - 1; j > 0; j--) shist[j] = shist[j-1];
      shist[0] = s;
      nf = mf;
      for (int i = 0; i < NUM_IRQ_DEF; i++) begin
        flip = 1'b1;
        for (int j = 0; j < FC; j++) if (shist[j][i] == mf[i]) flip = 1'b0;
        if (flip) nf[i] = ~mf[i];
      end
      rise     = mf & ~mfd;
      clrv     = bus.ack ? (irq_vec_t'(1) << bus.ack_id) : '0;
      entering = bus.edge_mode & ~mmode;
      npend    = (~bus.edge_mode & mf)
               | (bus.edge_mode & ~entering & ((mpend & ~clrv) | rise))
               | (entering & rise);
      movr     = (bus.edge_mode & ~entering & rise & mpend & ~clrv) | (movr & ~bus.overrun_clr);
      mpend    = npend;
      for (int j = SS - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = bus.irq_raw;
      mmode = bus.edge_mode;
      mfd   = mf;
      mf    = nf;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_pending", bus.irq_pending, mpend);
    check("model_overrun", bus.overrun, movr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drive(input irq_vec_t raw, input irq_vec_t em, input logic ack,
                       input irq_id_t id, input irq_vec_t oclr);
    bus.irq_raw     = raw;
    bus.edge_mode   = em;
    bus.ack         = ack;
    bus.ack_id      = id;
    bus.overrun_clr = oclr;
  endtask

  initial begin
    bus.polarity = '0;
    drive('0, '0, 1'b0, '0, '0);

    // Level on line 3, then edge on line 5 held high through an ack.
    tbl.push_back('{8'h08, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h08, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h08, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h08, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h08, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h08, 8'h00, 1'b0, 3'd0, 8'h08, 8'h00});
    tbl.push_back('{8'h08, 8'h00, 1'b1, 3'd3, 8'h08, 8'h00});
    for (int k = 0; k < 5; k++) tbl.push_back('{8'h00, 8'h00, 1'b0, 3'd0, 8'h08, 8'h00});
    tbl.push_back('{8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 8'h20, 1'b0, 3'd0, 8'h00, 8'h00});
    for (int k = 0; k < 5; k++) tbl.push_back('{8'h20, 8'h20, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h20, 8'h20, 1'b0, 3'd0, 8'h20, 8'h00});
    tbl.push_back('{8'h20, 8'h20, 1'b1, 3'd5, 8'h00, 8'h00});
    tbl.push_back('{8'h20, 8'h20, 1'b0, 3'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h20, 8'h20, 1'b0, 3'd0, 8'h00, 8'h00});
    for (int k = 0; k < 6; k++) tbl.push_back('{8'h00, 8'h20, 1'b0, 3'd0, 8'h00, 8'h00});

    // Reset state
    rst = 1'b1;
    step();
    check("reset_pending", bus.irq_pending, 8'h00);
    check("reset_overrun", bus.overrun, 8'h00);
    step();
    rst = 1'b0;
    idle(6);

    foreach (tbl[r]) begin
      drive(tbl[r].raw, tbl[r].em, tbl[r].ack, tbl[r].id, '0);
      step();
      check($sformatf("tbl%0d_pending", r), bus.irq_pending, tbl[r].exp_p);
      check($sformatf("tbl%0d_overrun", r), bus.overrun, tbl[r].exp_o);
    end

    // Glitch: 2-cycle pulse rejected, 3-cycle pulse accepted for 3 cycles.
    drive('0, '0, 1'b0, '0, '0);
    idle(8);
    bus.irq_raw = 8'h01;
    idle(2);
    bus.irq_raw = 8'h00;
    for (int j = 0; j < 8; j++) begin
      step();
      check("glitch2_pending", bus.irq_pending, 8'h00);
    end
    for (int j = 0; j < 12; j++) begin
      bus.irq_raw = (j < 3) ? 8'h01 : 8'h00;
      step();
      check("pulse3_pending", bus.irq_pending, (j >= 5 && j <= 7) ? 8'h01 : 8'h00);
    end

    // Edge collision and overrun on line 2.
    drive('0, 8'h04, 1'b0, '0, '0);
    idle(8);
    bus.irq_raw = 8'h04;
    idle(6);
    check("edge2_set", bus.irq_pending, 8'h04);
    bus.irq_raw = 8'h00;
    idle(8);
    check("edge2_held_after_fall", bus.irq_pending, 8'h04);
    bus.irq_raw = 8'h04;
    idle(5);
    bus.ack = 1'b1; bus.ack_id = 3'd2;
    step();
    bus.ack = 1'b0;
    check("collision_pending", bus.irq_pending, 8'h04);
    check("collision_overrun", bus.overrun, 8'h00);
    bus.irq_raw = 8'h00;
    idle(8);
    bus.irq_raw = 8'h04;
    idle(6);
    check("overrun_set", bus.overrun, 8'h04);
    step();
    check("overrun_sticky", bus.overrun, 8'h04);
    bus.overrun_clr = 8'h04;
    step();
    bus.overrun_clr = 8'h00;
    check("overrun_clr", bus.overrun, 8'h00);
    bus.ack = 1'b1; bus.ack_id = 3'd6;
    step();
    check("ack_other_noop", bus.irq_pending, 8'h04);
    bus.ack_id = 3'd2;
    step();
    bus.ack = 1'b0;
    check("ack2_clears", bus.irq_pending, 8'h00);

    // Polarity: active-low line 7 held high (inactive) across reset release.
    drive(8'h80, 8'h00, 1'b0, '0, '0);
    bus.polarity = 8'h80;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      check("pol_idle", bus.irq_pending, 8'h00);
    end
    bus.irq_raw = 8'h00;
    for (int j = 0; j < 8; j++) begin
      step();
      check("pol_assert", bus.irq_pending, (j >= 5) ? 8'h80 : 8'h00);
    end

    // Reset mid-operation with pending=A5 and overrun=01.
    bus.polarity = 8'h00;
    drive(8'h00, 8'h01, 1'b0, '0, '0);
    idle(8);
    bus.irq_raw = 8'h01; idle(6);
    bus.irq_raw = 8'h00; idle(6);
    bus.irq_raw = 8'h01; idle(6);
    bus.irq_raw = 8'hA5; idle(6);
    check("pre_reset_pending", bus.irq_pending, 8'hA5);
    check("pre_reset_overrun", bus.overrun, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_pending", bus.irq_pending, 8'h00);
    check("midreset_overrun", bus.overrun, 8'h00);
    for (int j = 0; j < 8; j++) begin
      step();
      check("post_reset_pending", bus.irq_pending, (j >= 5) ? 8'hA5 : 8'h00);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NUM_IRQ_DEF; i++)
        if ($urandom_range(0, 5) == 0) bus.irq_raw[i] = ~bus.irq_raw[i];
      if ($urandom_range(0, 99) == 0)  bus.edge_mode = irq_vec_t'($urandom);
      if ($urandom_range(0, 199) == 0) bus.polarity  = irq_vec_t'($urandom);
      bus.ack         = ($urandom_range(0, 3) == 0);
      bus.ack_id      = irq_id_t'($urandom_range(0, NUM_IRQ_DEF - 1));
      bus.overrun_clr = ($urandom_range(0, 7) == 0) ? irq_vec_t'($urandom) : '0;
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
